// File: rtl/cmp_hyst_array.sv
// cmp_hyst_array: multi-channel unsigned comparator with hysteresis,
// debounce and an optional sticky-latch mode.
//
// Ports:
//   clk    - system clock, all registers update on the rising edge
//   rst    - synchronous active-high reset, highest priority
//   en     - sample enable; when low every piece of state holds
//   sticky - 0 = hysteretic mode, 1 = sticky-latch mode (out holds once set)
//   clr    - synchronous clear of out, debounce/sample counters and valid
//   a, b   - packed operands, channel c uses bits [c*WIDTH +: WIDTH]
//   out    - registered comparator decision per channel
//   chg    - one-cycle pulse in the cycle after out[c] changes
//   valid  - high once DEBOUNCE enabled samples were taken since rst/clr
module cmp_hyst_array #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4,
  parameter int HYST     = 1,
  parameter int DEBOUNCE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sticky,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       chg,
  output logic [CHANNELS-1:0]       valid
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DC_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] SC_FULL  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH:0]   HYST_X   = (WIDTH + 1)'(HYST);

  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] chg_q, chg_d;
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]    dc_q [CHANNELS];
  logic [CNT_W-1:0]    dc_d [CHANNELS];
  logic [CNT_W-1:0]    sc_q [CHANNELS];
  logic [CNT_W-1:0]    sc_d [CHANNELS];

  logic [WIDTH:0]      a_x  [CHANNELS];
  logic [WIDTH:0]      b_x  [CHANNELS];
  logic [CHANNELS-1:0] q_s;

  // Qualifying condition per channel, widened by one bit so the hysteresis
  // offset can never wrap (a=b=max with HYST=1 must not qualify).
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      a_x[c] = {1'b0, a[c*WIDTH +: WIDTH]};
      b_x[c] = {1'b0, b[c*WIDTH +: WIDTH]};
      if (out_q[c]) begin
        // A latched sticky channel can only be released by clr or rst.
        if (sticky) begin
          q_s[c] = 1'b0;
        end else begin
          q_s[c] = (a_x[c] + HYST_X) < b_x[c];
        end
      end else begin
        q_s[c] = a_x[c] > (b_x[c] + HYST_X);
      end
    end
  end

  // Next-state logic: clr beats any due toggle; en low freezes everything
  // except chg, which is only ever a single-cycle pulse.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    chg_d   = '0;
    dc_d    = dc_q;
    sc_d    = sc_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (clr) begin
        chg_d[c]   = out_q[c];
        out_d[c]   = 1'b0;
        valid_d[c] = 1'b0;
        dc_d[c]    = '0;
        sc_d[c]    = '0;
      end else if (en) begin
        // Sample counter saturates at DEBOUNCE; valid sets on reaching it.
        if (sc_q[c] != SC_FULL) begin
          sc_d[c] = sc_q[c] + CNT_ONE;
        end else begin
          sc_d[c] = sc_q[c];
        end
        if (sc_q[c] >= DC_LAST) begin
          valid_d[c] = 1'b1;
        end else begin
          valid_d[c] = valid_q[c];
        end
        if (!q_s[c]) begin
          dc_d[c] = '0;
        end else if (dc_q[c] == DC_LAST) begin
          out_d[c] = ~out_q[c];
          chg_d[c] = 1'b1;
          dc_d[c]  = '0;
        end else begin
          dc_d[c] = dc_q[c] + CNT_ONE;
        end
      end else begin
        out_d[c] = out_q[c];
        dc_d[c]  = dc_q[c];
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      chg_q   <= '0;
      valid_q <= '0;
      dc_q    <= '{default: '0};
      sc_q    <= '{default: '0};
    end else begin
      out_q   <= out_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
      dc_q    <= dc_d;
      sc_q    <= sc_d;
    end
  end

  assign out   = out_q;
  assign chg   = chg_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_cmp_hyst_array.sv
// Testbench for cmp_hyst_array (CHANNELS=2, WIDTH=4, HYST=1, DEBOUNCE=3).
// Directed vector table with constant expectations, then randomized
// stimulus checked against a behavioural model of the channel rules.
module tb_cmp_hyst_array;

  localparam int CH  = 2;
  localparam int W   = 4;
  localparam int H   = 1;
  localparam int DEB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sticky = 1'b0;
  logic          clr = 1'b0;
  logic [CH*W-1:0] a = '0;
  logic [CH*W-1:0] b = '0;
  logic [CH-1:0] out, chg, valid;

  cmp_hyst_array #(.CHANNELS(CH), .WIDTH(W), .HYST(H), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .sticky(sticky), .clr(clr),
    .a(a), .b(b), .out(out), .chg(chg), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, sticky, clr;
    logic [7:0] a, b;
    logic [1:0] eo, ec, ev;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  // Behavioural model state
  int m_out[CH];
  int m_dc[CH];
  int m_chg[CH];
  int m_samples;

  task automatic add(input logic r, e, s, cl, input logic [7:0] av, bv,
                     input logic [1:0] eo, ec, ev);
    vec_t v;
    v.rst = r; v.en = e; v.sticky = s; v.clr = cl; v.a = av; v.b = bv;
    v.eo = eo; v.ec = ec; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int av, bv;
    bit q;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin m_out[c] = 0; m_dc[c] = 0; m_chg[c] = 0; end
      m_samples = 0;
    end else if (clr) begin
      for (int c = 0; c < CH; c++) begin m_chg[c] = m_out[c]; m_out[c] = 0; m_dc[c] = 0; end
      m_samples = 0;
    end else begin
      for (int c = 0; c < CH; c++) m_chg[c] = 0;
      if (en) begin
        if (m_samples < DEB) m_samples++;
        for (int c = 0; c < CH; c++) begin
          av = int'(a[c*W +: W]);
          bv = int'(b[c*W +: W]);
          if (m_out[c] == 0) q = (av > bv + H);
          else q = sticky ? 1'b0 : (av + H < bv);
          if (!q) m_dc[c] = 0;
          else begin
            m_dc[c]++;
            if (m_dc[c] == DEB) begin
              m_out[c] = 1 - m_out[c];
              m_dc[c] = 0;
              m_chg[c] = 1;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [1:0] pack2(input int v0, input int v1);
    logic [1:0] r;
    r[0] = (v0 != 0);
    r[1] = (v1 != 0);
    return r;
  endfunction

  task automatic apply(input logic r, e, s, cl, input logic [7:0] av, bv, input string tag);
    rst = r; en = e; sticky = s; clr = cl; a = av; b = bv;
    model_step();
    @(posedge clk);
    #1;
    chk({tag, " model out"}, out, pack2(m_out[0], m_out[1]));
    chk({tag, " model chg"}, chg, pack2(m_chg[0], m_chg[1]));
    chk({tag, " model valid"}, valid, {2{m_samples >= DEB}});
  endtask

  initial begin
    int hold;
    logic [7:0] ra, rb;
    logic rs;

    // Reset and valid ramp
    add(1,0,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b00);
    add(1,0,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b11);
    // Rise on ch0 after 3 edges, chg one cycle
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b01,2'b01,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b01,2'b00,2'b11);
    // Hysteresis band holds out=1
    for (int i = 0; i < 10; i++) add(0,1,0,0, 8'h03,8'h03, 2'b01,2'b00,2'b11);
    // Fall: 2+1 < 4
    add(0,1,0,0, 8'h02,8'h04, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h02,8'h04, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h02,8'h04, 2'b00,2'b01,2'b11);
    add(0,1,0,0, 8'h02,8'h04, 2'b00,2'b00,2'b11);
    // No wrap at max operands
    for (int i = 0; i < 4; i++) add(0,1,0,0, 8'h0F,8'h0F, 2'b00,2'b00,2'b11);
    // Glitch filter
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h04,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h00,8'h03, 2'b00,2'b00,2'b11);
    // Enable hold: run survives en-low gap
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,0,0, 8'h05,8'h03, 2'b01,2'b01,2'b11);
    add(0,0,0,0, 8'h05,8'h03, 2'b01,2'b00,2'b11);
    // Fall back to 0
    add(0,1,0,0, 8'h00,8'h0F, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h00,8'h0F, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h00,8'h0F, 2'b00,2'b01,2'b11);
    add(0,1,0,0, 8'h00,8'h0F, 2'b00,2'b00,2'b11);
    // Sticky latch
    add(0,1,1,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,1,0, 8'h05,8'h03, 2'b00,2'b00,2'b11);
    add(0,1,1,0, 8'h05,8'h03, 2'b01,2'b01,2'b11);
    for (int i = 0; i < 10; i++) add(0,1,1,0, 8'h00,8'h0F, 2'b01,2'b00,2'b11);
    add(0,1,1,1, 8'h00,8'h0F, 2'b00,2'b01,2'b00);
    add(0,1,0,0, 8'h00,8'h00, 2'b00,2'b00,2'b00);
    // clr on the same edge as a due ch1 toggle
    add(0,1,0,0, 8'h50,8'h30, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h50,8'h30, 2'b00,2'b00,2'b11);
    add(0,1,0,1, 8'h50,8'h30, 2'b00,2'b00,2'b00);
    // Channel independence with simultaneous toggles
    add(0,1,0,0, 8'h29,8'h92, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h29,8'h92, 2'b00,2'b00,2'b00);
    add(0,1,0,0, 8'h29,8'h92, 2'b01,2'b01,2'b11);
    add(0,1,0,0, 8'h92,8'h29, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h92,8'h29, 2'b01,2'b00,2'b11);
    add(0,1,0,0, 8'h92,8'h29, 2'b10,2'b11,2'b11);
    add(0,1,0,0, 8'h92,8'h29, 2'b10,2'b00,2'b11);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].rst, vecs[i].en, vecs[i].sticky, vecs[i].clr, vecs[i].a, vecs[i].b, tag);
      chk({tag, " out"}, out, vecs[i].eo);
      chk({tag, " chg"}, chg, vecs[i].ec);
      chk({tag, " valid"}, valid, vecs[i].ev);
    end

    // Randomized phase: operands held for a few cycles so runs can complete.
    hold = 0;
    ra = '0;
    rb = '0;
    rs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        hold = int'($urandom_range(1, 7));
      end
      hold--;
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) != 0), rs,
            ($urandom_range(0, 49) == 0), ra, rb, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
